dbg_sba_mem_arbiter: RTL and testbench

Round-robin arbiter sharing the single memory-style port in front of the debug subsystem's mem-to-AXI bridge between NumReq requesters. Requester 0 is the debug module system bus access; the others are auxiliary masters such as a trace or test DMA. It locks the grant while the downstream port stalls. It tracks outstanding requests in an in-order ID FIFO and routes each response back to the requester that issued it.

---
 rtl/core_v_mcu_pkg.sv | 14 +
 rtl/dbg_sba_id_fifo.sv | 56 +++++
 rtl/dbg_sba_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_dbg_sba_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_v_mcu_pkg.sv
// Shared SoC-level constants for the core-v-mcu debug subsystem, plus a small index helper.
package core_v_mcu_pkg;

   localparam int unsigned AxiAddrWidth         = 32;
   localparam int unsigned AxiDataWidth         = 32;
   localparam int unsigned DbgSbaNumReq         = 2;
   localparam int unsigned DbgSbaMaxOutstanding = 4;

   // Increment an index, wrapping back to zero at n.
   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/dbg_sba_id_fifo.sv
// In-order FIFO of requester IDs for issued-but-unanswered requests.
module dbg_sba_id_fifo
   import core_v_mcu_pkg::*;
#(
   parameter int unsigned Depth = DbgSbaMaxOutstanding,
   parameter int unsigned Width = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [Width-1:0] head_o
);

   localparam int unsigned PtrW   = $clog2(Depth);
   localparam int unsigned CountW = PtrW + 1;

   logic [Width-1:0]  mem_q [Depth];
   logic [PtrW-1:0]   wr_ptr;
   logic [PtrW-1:0]   rd_ptr;
   logic [CountW-1:0] count;
   logic              do_push;
   logic              do_pop;

   assign full_o  = (count == CountW'(Depth));
   assign empty_o = (count == '0);
   assign head_o  = mem_q[rd_ptr];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // NOTE: storage is not reset; count gates every read, so stale entries are never observed.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr] <= data_i;
   end

   // Depth is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dbg_sba_mem_arbiter.sv
// Round-robin arbiter in front of the debug mem-to-AXI bridge. The grant locks across
// downstream stalls; responses are routed back through an in-order ID FIFO.
module dbg_sba_mem_arbiter
   import core_v_mcu_pkg::*;
#(
   parameter int unsigned NumReq         = DbgSbaNumReq,
   parameter int unsigned MaxOutstanding = DbgSbaMaxOutstanding,
   parameter int unsigned AddrWidth      = AxiAddrWidth,
   parameter int unsigned DataWidth      = AxiDataWidth
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NumReq-1:0]                   req_i,
   input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
   input  logic [NumReq-1:0]                   we_i,
   input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
   input  logic [NumReq-1:0][DataWidth/8-1:0]  be_i,
   output logic [NumReq-1:0]                   gnt_o,
   output logic [NumReq-1:0]                   rvalid_o,
   output logic [DataWidth-1:0]                rdata_o,
   output logic                                err_o,
   output logic                                mem_req_o,
   output logic [AddrWidth-1:0]                mem_addr_o,
   output logic                                mem_we_o,
   output logic [DataWidth-1:0]                mem_wdata_o,
   output logic [DataWidth/8-1:0]              mem_be_o,
   input  logic                                mem_gnt_i,
   input  logic                                mem_rsp_valid_i,
   input  logic [DataWidth-1:0]                mem_rsp_rdata_i,
   input  logic                                mem_rsp_error_i,
   output logic                                busy_o,
   output logic                                unexp_rsp_o
);

   typedef logic [$clog2(NumReq)-1:0] idx_t;

   idx_t rr_ptr;
   idx_t lock_idx;
   logic lock;
   idx_t sel;
   idx_t cand;
   logic sel_valid;
   idx_t head;
   logic fifo_full;
   logic fifo_empty;
   logic handshake;
   logic pop;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      sel       = rr_ptr;
      cand      = rr_ptr;
      sel_valid = 1'b0;
      if (lock) begin
         sel       = lock_idx;
         sel_valid = req_i[lock_idx];
      end else begin
         for (int k = 0; k < int'(NumReq); k++) begin
            cand = idx_t'((int'(rr_ptr) + k) % NumReq);
            if (!sel_valid && req_i[cand]) begin
               sel       = cand;
               sel_valid = 1'b1;
            end
         end
      end
   end

   // Full is taken from the registered count only, so a same-cycle response cannot unblock.
   assign mem_req_o   = sel_valid & ~fifo_full;
   assign handshake   = mem_req_o & mem_gnt_i;
   assign mem_addr_o  = addr_i[sel];
   assign mem_we_o    = we_i[sel];
   assign mem_wdata_o = wdata_i[sel];
   assign mem_be_o    = be_i[sel];

   assign pop     = mem_rsp_valid_i & ~fifo_empty;
   assign rdata_o = pop ? mem_rsp_rdata_i : '0;
   assign err_o   = pop & mem_rsp_error_i;
   assign busy_o  = ~fifo_empty;

   always_comb begin
      gnt_o          = '0;
      rvalid_o       = '0;
      gnt_o[sel]     = handshake;
      rvalid_o[head] = pop;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr      <= '0;
         lock        <= 1'b0;
         lock_idx    <= '0;
         unexp_rsp_o <= 1'b0;
      end else begin
         if (handshake) begin
            lock   <= 1'b0;
            rr_ptr <= idx_t'(wrap_inc(int'(sel), int'(NumReq)));
         end else if (mem_req_o) begin
            lock     <= 1'b1;
            lock_idx <= sel;
         end
         if (mem_rsp_valid_i && fifo_empty) unexp_rsp_o <= 1'b1;
      end
   end

   dbg_sba_id_fifo #(
      .Depth (MaxOutstanding),
      .Width ($clog2(NumReq))
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (handshake),
      .data_i  (sel),
      .pop_i   (pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head)
   );

endmodule

// File: tb/tb_dbg_sba_mem_arbiter.sv
// Self-checking bench for dbg_sba_mem_arbiter: directed vector table, hand sequences, random vs model.
module tb_dbg_sba_mem_arbiter;
   import core_v_mcu_pkg::*;

   localparam int N  = 2;
   localparam int MO = 4;
   localparam int AW = AxiAddrWidth;
   localparam int DW = AxiDataWidth;
   localparam int BW = DW / 8;
   localparam logic [AW-1:0] A0 = 32'h0000_1000;
   localparam logic [AW-1:0] A1 = 32'h0000_2000;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [N-1:0]           req;
   logic [N-1:0][AW-1:0]   addr;
   logic [N-1:0]           we;
   logic [N-1:0][DW-1:0]   wdata;
   logic [N-1:0][BW-1:0]   be;
   logic [N-1:0]           gnt;
   logic [N-1:0]           rvalid;
   logic [DW-1:0]          rdata;
   logic                   err;
   logic                   mem_req;
   logic [AW-1:0]          mem_addr;
   logic                   mem_we;
   logic [DW-1:0]          mem_wdata;
   logic [BW-1:0]          mem_be;
   logic                   mem_gnt;
   logic                   rsp_valid;
   logic [DW-1:0]          rsp_rdata;
   logic                   rsp_err;
   logic                   busy;
   logic                   unexp;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dbg_sba_mem_arbiter #(
      .NumReq         (N),
      .MaxOutstanding (MO),
      .AddrWidth      (AW),
      .DataWidth      (DW)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .req_i           (req),
      .addr_i          (addr),
      .we_i            (we),
      .wdata_i         (wdata),
      .be_i            (be),
      .gnt_o           (gnt),
      .rvalid_o        (rvalid),
      .rdata_o         (rdata),
      .err_o           (err),
      .mem_req_o       (mem_req),
      .mem_addr_o      (mem_addr),
      .mem_we_o        (mem_we),
      .mem_wdata_o     (mem_wdata),
      .mem_be_o        (mem_be),
      .mem_gnt_i       (mem_gnt),
      .mem_rsp_valid_i (rsp_valid),
      .mem_rsp_rdata_i (rsp_rdata),
      .mem_rsp_error_i (rsp_err),
      .busy_o          (busy),
      .unexp_rsp_o     (unexp)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic settle();
      #4;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req       = '0;
      mem_gnt   = 1'b1;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_rdata = '0;
   endtask

   // One directed cycle: inputs plus the expected outputs for that same cycle.
   typedef struct {
      logic [N-1:0] req;
      logic         mg;
      logic         rv;
      logic         re;
      logic [N-1:0] e_gnt;
      logic [N-1:0] e_rvalid;
      logic         e_req;
      int           e_sel;
      logic         e_err;
      logic         e_busy;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic [N-1:0] r, input logic mg, input logic rv, input logic re,
                               input logic [N-1:0] eg, input logic [N-1:0] erv, input logic ereq,
                               input int esel, input logic eerr, input logic ebusy);
      vec_t v;
      v.req = r;  v.mg = mg;  v.rv = rv;  v.re = re;
      v.e_gnt = eg;  v.e_rvalid = erv;  v.e_req = ereq;
      v.e_sel = esel;  v.e_err = eerr;  v.e_busy = ebusy;
      return v;
   endfunction

   // Behavioural reference for the random phase.
   int   m_rr;
   bit   m_lock;
   int   m_lock_who;
   int   m_q[$];
   bit   m_unexp;
   bit   pend[N];

   task automatic model_reset();
      m_rr = 0;  m_lock = 0;  m_lock_who = 0;  m_unexp = 0;
      m_q.delete();
      for (int i = 0; i < N; i++) pend[i] = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [DW-1:0] e_rdata;
      int            who;
      int            best;
      logic          e_mreq;
      logic          e_hs;
      logic          e_pop;
      logic [N-1:0]  e_gnt;
      logic [N-1:0]  e_rv;

      addr[0] = A0;  addr[1] = A1;
      we[0] = 1'b0;  we[1] = 1'b1;
      wdata[0] = 32'h1111_1111;  wdata[1] = 32'h2222_2222;
      be[0] = 4'hF;  be[1] = 4'h3;
      idle_inputs();
      rst = 1'b1;
      #1;

      // ---- reset state ----
      next_cycle();
      settle();
      check("rst.gnt", gnt, 0);
      check("rst.rvalid", rvalid, 0);
      check("rst.mem_req", mem_req, 0);
      check("rst.busy", busy, 0);
      check("rst.unexp", unexp, 0);
      check("rst.err", err, 0);
      check("rst.rdata", rdata, 0);
      next_cycle();
      rst = 1'b0;

      // ---- directed table: alternation, error routing, full FIFO ----
      vt.push_back(mk(2'b11, 1, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0));
      vt.push_back(mk(2'b11, 1, 1, 0, 2'b10, 2'b01, 1, 1, 0, 1));
      vt.push_back(mk(2'b11, 1, 1, 0, 2'b01, 2'b10, 1, 0, 0, 1));
      vt.push_back(mk(2'b11, 1, 1, 0, 2'b10, 2'b01, 1, 1, 0, 1));
      vt.push_back(mk(2'b00, 1, 1, 0, 2'b00, 2'b10, 0, 0, 0, 1));
      vt.push_back(mk(2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
      vt.push_back(mk(2'b10, 1, 0, 0, 2'b10, 2'b00, 1, 1, 0, 0));
      vt.push_back(mk(2'b01, 1, 1, 0, 2'b01, 2'b10, 1, 0, 0, 1));
      vt.push_back(mk(2'b10, 1, 1, 1, 2'b10, 2'b01, 1, 1, 1, 1));
      vt.push_back(mk(2'b00, 1, 1, 0, 2'b00, 2'b10, 0, 0, 0, 1));
      vt.push_back(mk(2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
      vt.push_back(mk(2'b01, 1, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0));
      for (int i = 0; i < 3; i++) vt.push_back(mk(2'b01, 1, 0, 0, 2'b01, 2'b00, 1, 0, 0, 1));
      vt.push_back(mk(2'b01, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1));
      vt.push_back(mk(2'b01, 1, 1, 0, 2'b00, 2'b01, 0, 0, 0, 1));
      vt.push_back(mk(2'b01, 1, 0, 0, 2'b01, 2'b00, 1, 0, 0, 1));
      for (int i = 0; i < 4; i++) vt.push_back(mk(2'b00, 1, 1, 0, 2'b00, 2'b01, 0, 0, 0, 1));
      vt.push_back(mk(2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));

      foreach (vt[i]) begin
         req       = vt[i].req;
         mem_gnt   = vt[i].mg;
         rsp_valid = vt[i].rv;
         rsp_err   = vt[i].re;
         rsp_rdata = 32'hA500_0000 + DW'(i);
         settle();
         check($sformatf("v%0d.gnt", i), gnt, vt[i].e_gnt);
         check($sformatf("v%0d.rvalid", i), rvalid, vt[i].e_rvalid);
         check($sformatf("v%0d.mem_req", i), mem_req, vt[i].e_req);
         check($sformatf("v%0d.err", i), err, vt[i].e_err);
         check($sformatf("v%0d.busy", i), busy, vt[i].e_busy);
         check($sformatf("v%0d.unexp", i), unexp, 0);
         e_rdata = (vt[i].e_rvalid != 0) ? rsp_rdata : '0;
         check($sformatf("v%0d.rdata", i), rdata, e_rdata);
         if (vt[i].e_req)
            check($sformatf("v%0d.addr", i), mem_addr, (vt[i].e_sel == 1) ? A1 : A0);
         next_cycle();
      end
      idle_inputs();

      // ---- stall lock: rr points at requester 1, yet req0 stays locked ----
      for (int c = 0; c < 5; c++) begin
         req       = (c == 0) ? 2'b01 : (c == 4) ? 2'b10 : 2'b11;
         mem_gnt   = (c >= 3);
         settle();
         check($sformatf("lock%0d.mem_req", c), mem_req, 1);
         check($sformatf("lock%0d.addr", c), mem_addr, (c == 4) ? A1 : A0);
         check($sformatf("lock%0d.gnt", c), gnt, (c == 3) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00);
         next_cycle();
      end
      req = '0;
      for (int c = 0; c < 2; c++) begin
         rsp_valid = 1'b1;
         settle();
         check($sformatf("lockrsp%0d.rvalid", c), rvalid, (c == 0) ? 2'b01 : 2'b10);
         next_cycle();
      end
      rsp_valid = 1'b0;
      settle();
      check("lock.busy_idle", busy, 0);
      next_cycle();

      // ---- unexpected response with empty FIFO ----
      rsp_valid = 1'b1;
      rsp_rdata = 32'hDEAD_BEEF;
      settle();
      check("unexp.rvalid", rvalid, 0);
      check("unexp.before", unexp, 0);
      next_cycle();
      rsp_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         settle();
         check($sformatf("unexp.held%0d", c), unexp, 1);
         next_cycle();
      end

      // ---- reset with two outstanding requests, then two late responses ----
      req = 2'b01;
      for (int c = 0; c < 2; c++) begin
         settle();
         check($sformatf("rstmid.gnt%0d", c), gnt, 2'b01);
         next_cycle();
      end
      req = '0;
      settle();
      check("rstmid.busy_before", busy, 1);
      rst = 1'b1;
      #1;
      check("rstmid.busy_async", busy, 0);
      next_cycle();
      rst = 1'b0;
      settle();
      check("rstmid.unexp_cleared", unexp, 0);
      next_cycle();
      for (int c = 0; c < 2; c++) begin
         rsp_valid = 1'b1;
         settle();
         check($sformatf("rstmid.late_rvalid%0d", c), rvalid, 0);
         next_cycle();
      end
      rsp_valid = 1'b0;
      settle();
      check("rstmid.unexp", unexp, 1);
      check("rstmid.busy", busy, 0);
      next_cycle();

      // ---- randomized traffic against the behavioural model ----
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i]  = 1;
               addr[i]  = $urandom;
               we[i]    = 1'($urandom);
               wdata[i] = $urandom;
               be[i]    = 4'($urandom);
            end
            req[i] = pend[i];
         end
         mem_gnt   = ($urandom_range(0, 3) != 0);
         rsp_valid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
         rsp_err   = 1'($urandom);
         rsp_rdata = $urandom;

         who = -1;
         if (m_lock) begin
            who = m_lock_who;
         end else begin
            best = N;
            for (int i = 0; i < N; i++)
               if (req[i] && ((i - m_rr + N) % N) < best) begin
                  best = (i - m_rr + N) % N;
                  who  = i;
               end
         end
         e_mreq = (who >= 0) && req[who] && (m_q.size() < MO);
         e_hs   = e_mreq && mem_gnt;
         e_pop  = rsp_valid && (m_q.size() > 0);
         e_gnt  = '0;
         if (e_hs) e_gnt[who] = 1'b1;
         e_rv   = '0;
         if (e_pop) e_rv[m_q[0]] = 1'b1;

         settle();
         check($sformatf("rnd%0d.mem_req", cyc), mem_req, e_mreq);
         check($sformatf("rnd%0d.gnt", cyc), gnt, e_gnt);
         check($sformatf("rnd%0d.rvalid", cyc), rvalid, e_rv);
         check($sformatf("rnd%0d.rdata", cyc), rdata, e_pop ? rsp_rdata : '0);
         check($sformatf("rnd%0d.err", cyc), err, e_pop && rsp_err);
         check($sformatf("rnd%0d.busy", cyc), busy, m_q.size() != 0);
         check($sformatf("rnd%0d.unexp", cyc), unexp, m_unexp);
         if (e_mreq) begin
            check($sformatf("rnd%0d.addr", cyc), mem_addr, addr[who]);
            check($sformatf("rnd%0d.we", cyc), mem_we, we[who]);
            check($sformatf("rnd%0d.wdata", cyc), mem_wdata, wdata[who]);
            check($sformatf("rnd%0d.be", cyc), mem_be, be[who]);
         end

         if (e_pop) void'(m_q.pop_front());
         else if (rsp_valid) m_unexp = 1;
         if (e_hs) begin
            m_q.push_back(who);
            m_rr   = (who + 1) % N;
            m_lock = 0;
            pend[who] = 0;
         end else if (e_mreq) begin
            m_lock     = 1;
            m_lock_who = who;
         end
         next_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
